// File: rtl/request_capture_queue.sv
// Request capture queue: synchronises 16 request lines into sticky pending bits and presents the
// highest pending index with a valid/ack handshake. Define EDGE_DETECT_EN for rising-edge capture.
module request_capture_queue (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ena,
   input  logic [15:0] ui_in,
   input  logic [7:0]  uio_in,
   output logic [7:0]  uo_out,
   output logic [7:0]  uio_out,
   output logic [7:0]  uio_oe
);

   typedef enum logic {StIdle, StPresent} state_e;

   state_e      state_q;
   logic [15:0] s1_q, s2_q;
   logic [15:0] pending_q, pending_d;
   logic [15:0] event_vec;
   logic [15:0] ack_mask;
   logic [3:0]  idx_q;
   logic [3:0]  top_idx;
   logic [3:0]  count_q, count_d;
   logic [4:0]  pop;
   logic [7:0]  code_q;
   logic        valid_q;
   logic        ack, clear_all, ack_accept;
   logic        overflow_flag;
   logic        unused_uio;

   assign ack        = uio_in[0];
   assign clear_all  = uio_in[1];
   assign unused_uio = ^uio_in[7:2];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         s2_q <= '0;
      end else if (ena) begin
         s1_q <= ui_in;
         s2_q <= s1_q;
      end
   end

`ifdef EDGE_DETECT_EN
   logic [15:0] prev_q;
   logic        overflow_q, overflow_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= '0;
      end else if (ena) begin
         prev_q <= s2_q;
      end
   end

   assign event_vec = s2_q & ~prev_q;

   // A fresh event on a bit that is still pending (and not being acked) means a lost request.
   always_comb begin
      overflow_d = overflow_q | (|(event_vec & pending_q & ~ack_mask));
      if (clear_all) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
      end else if (ena) begin
         overflow_q <= overflow_d;
      end
   end

   assign overflow_flag = overflow_q;
`else
   assign event_vec     = s2_q;
   assign overflow_flag = 1'b0;
`endif

   always_comb begin
      ack_accept = (state_q == StPresent) && ack && !clear_all;
      ack_mask   = ack_accept ? (16'h0001 << idx_q) : 16'h0000;
      // Set wins over ack on the same bit.
      pending_d  = (pending_q & ~ack_mask) | event_vec;
      if (clear_all) begin
         pending_d = '0;
      end
   end

   always_comb begin
      pop = 5'd0;
      for (int i = 0; i < 16; i++) begin
         pop = pop + {4'b0000, pending_d[i]};
      end
      count_d = pop[4] ? 4'hF : pop[3:0];
   end

   always_comb begin
      top_idx = 4'd0;
      for (int i = 0; i < 16; i++) begin
         if (pending_q[i]) begin
            top_idx = 4'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
         count_q   <= '0;
      end else if (ena) begin
         pending_q <= pending_d;
         count_q   <= count_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         idx_q   <= '0;
         valid_q <= 1'b0;
         code_q  <= 8'hF0;
      end else if (ena) begin
         if (clear_all) begin
            state_q <= StIdle;
            valid_q <= 1'b0;
            code_q  <= 8'hF0;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (pending_q != '0) begin
                     state_q <= StPresent;
                     idx_q   <= top_idx;
                     valid_q <= 1'b1;
                     code_q  <= {4'b0000, top_idx};
                  end
               end
               StPresent: begin
                  if (ack) begin
                     state_q <= StIdle;
                     valid_q <= 1'b0;
                     code_q  <= 8'hF0;
                  end
               end
               default: begin
                  state_q <= StIdle;
                  valid_q <= 1'b0;
                  code_q  <= 8'hF0;
               end
            endcase
         end
      end
   end

   assign uo_out  = code_q;
   assign uio_out = {count_q, overflow_flag, valid_q, 2'b00};
   assign uio_oe  = 8'hFC;

endmodule

// File: tb/tb_request_capture_queue.sv
// Randomised and directed bench for request_capture_queue against a behavioural model.
module tb_request_capture_queue;

   logic        clk;
   logic        rst_n;
   logic        ena;
   logic [15:0] ui_in;
   logic [7:0]  uio_in;
   logic [7:0]  uo_out;
   logic [7:0]  uio_out;
   logic [7:0]  uio_oe;

   int n_cmp;
   int n_err;

   // Behavioural model state.
   logic [15:0] m_s1, m_s2, m_prev;
   logic [15:0] m_pend;
   bit          m_ovf;
   bit          m_pres;
   int          m_idx;

   request_capture_queue dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_prev = '0;
      m_pend = '0; m_ovf = 0; m_pres = 0; m_idx = 0;
   endtask

   function automatic int highest(input logic [15:0] v);
      int h = 0;
      for (int i = 0; i < 16; i++) if (v[i]) h = i;
      return h;
   endfunction

   task automatic model_step(input logic [15:0] ui, input bit ack, input bit clr, input bit en);
      logic [15:0] ev, mask, old_pend;
      if (!en) return;
`ifdef EDGE_DETECT_EN
      ev = m_s2 & ~m_prev;
`else
      ev = m_s2;
`endif
      old_pend = m_pend;
      if (clr) begin
         m_pend = '0;
         m_ovf  = 0;
         m_pres = 0;
      end else begin
         mask = (m_pres && ack) ? (16'h0001 << m_idx) : 16'h0000;
`ifdef EDGE_DETECT_EN
         if ((ev & old_pend & ~mask) != 0) m_ovf = 1;
`endif
         m_pend = (old_pend & ~mask) | ev;
         if (m_pres) begin
            if (ack) m_pres = 0;
         end else if (old_pend != 0) begin
            m_idx  = highest(old_pend);
            m_pres = 1;
         end
      end
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = ui;
   endtask

   function automatic logic [7:0] exp_uo();
      return m_pres ? 8'(m_idx) : 8'hF0;
   endfunction

   function automatic logic [7:0] exp_uio();
      int c = $countones(m_pend);
      if (c > 15) c = 15;
      return {4'(c), m_ovf, m_pres, 2'b00};
   endfunction

   task automatic compare_all();
      check("uo_out", uo_out, exp_uo());
      check("uio_out", uio_out, exp_uio());
      check("uio_oe", uio_oe, 8'hFC);
   endtask

   task automatic cycle(input logic [15:0] ui, input bit ack, input bit clr, input bit en);
      @(negedge clk);
      ui_in  = ui;
      uio_in = {6'b101010, clr, ack};  // upper bits are don't-care
      ena    = en;
      @(posedge clk);
      model_step(ui, ack, clr, en);
      #1;
      compare_all();
   endtask

   task automatic wait_valid();
      bit ok = 0;
      for (int i = 0; i < 12 && !ok; i++) begin
         cycle(16'h0000, 0, 0, 1);
         if (uio_out[2]) ok = 1;
      end
      check("wait_valid", 32'(ok), 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = '0;
      uio_in = '0;
      model_reset();
      #12;
      check("reset_uo", uo_out, 8'hF0);
      check("reset_uio", uio_out, 8'h00);
      check("reset_oe", uio_oe, 8'hFC);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (10) cycle(16'h0000, 0, 0, 1);

      // Priority order.
      cycle(16'h8421, 0, 0, 1);
      wait_valid();
      check("prio_15", uo_out, 8'd15);
      cycle(16'h0000, 1, 0, 1);
      wait_valid();
      check("prio_10", uo_out, 8'd10);
      cycle(16'h0000, 1, 0, 1);
      wait_valid();
      check("prio_5", uo_out, 8'd5);
      cycle(16'h0000, 1, 0, 1);
      wait_valid();
      check("prio_0", uo_out, 8'd0);
      cycle(16'h0000, 1, 0, 1);
      repeat (3) cycle(16'h0000, 0, 0, 1);
      check("prio_empty", uo_out, 8'hF0);

      // Frozen code.
      cycle(16'h0008, 0, 0, 1);
      wait_valid();
      check("frozen_3", uo_out, 8'd3);
      cycle(16'h1000, 0, 0, 1);
      repeat (4) cycle(16'h0000, 0, 0, 1);
      check("frozen_hold", uo_out, 8'd3);
      cycle(16'h0000, 1, 0, 1);
      wait_valid();
      check("frozen_next", uo_out, 8'd12);
      cycle(16'h0000, 1, 0, 1);
      repeat (2) cycle(16'h0000, 0, 0, 1);

      // Overflow and clear_all.
      cycle(16'h0080, 0, 0, 1);
      cycle(16'h0000, 0, 0, 1);
      cycle(16'h0080, 0, 0, 1);
      repeat (4) cycle(16'h0000, 0, 0, 1);
`ifdef EDGE_DETECT_EN
      check("ovf_set", uio_out[3], 1'b1);
`else
      check("ovf_tied", uio_out[3], 1'b0);
`endif
      check("ovf_count", uio_out[7:4], 4'd1);
      cycle(16'h0000, 0, 1, 1);
      check("clr_uio", uio_out, 8'h00);
      check("clr_uo", uo_out, 8'hF0);
      repeat (2) cycle(16'h0000, 0, 0, 1);

      // Set wins: new event on bit 9 lands on the ack edge.
      cycle(16'h0200, 0, 0, 1);
      wait_valid();
      check("setwin_9", uo_out, 8'd9);
      cycle(16'h0200, 0, 0, 1);
      cycle(16'h0000, 0, 0, 1);
      cycle(16'h0000, 1, 0, 1);
      check("setwin_ovf", uio_out[3], 1'b0);
      check("setwin_cnt", uio_out[7:4], 4'd1);
      cycle(16'h0000, 0, 0, 1);
      check("setwin_again", uo_out, 8'd9);
      cycle(16'h0000, 1, 0, 1);
      repeat (2) cycle(16'h0000, 0, 0, 1);

      // ena low freezes the handshake; ack ignored.
      cycle(16'h0004, 0, 0, 1);
      wait_valid();
      repeat (3) cycle(16'hFFFF, 1, 0, 0);
      check("ena_hold", uo_out, 8'd2);
      cycle(16'h0000, 1, 0, 1);
      repeat (2) cycle(16'h0000, 0, 0, 1);

      // Asynchronous reset mid-handshake.
      cycle(16'h0040, 0, 0, 1);
      wait_valid();
      check("rst_pre", uo_out, 8'd6);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check("rst_async_uo", uo_out, 8'hF0);
      check("rst_async_uio", uio_out, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) cycle(16'h0000, 0, 0, 1);
      check("rst_no_code", uo_out, 8'hF0);

      // Randomised traffic.
      for (int n = 0; n < 400; n++) begin
         logic [15:0] ui;
         ui = ($urandom_range(0, 5) == 0) ? (16'h0001 << $urandom_range(0, 15)) : 16'h0000;
         if ($urandom_range(0, 20) == 0) ui = 16'($urandom);
         cycle(ui, $urandom_range(0, 2) == 0, $urandom_range(0, 60) == 0,
               $urandom_range(0, 9) != 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
